// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request at a time, a registered
// instruction holding slot toward the control unit, and redirect/kill handling.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        imem_rsp_err_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [6:0]  opcode_o,
    output logic [2:0]  func3_o,
    output logic [6:0]  func7_o,
    output logic        fetch_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] inst_pc_reg, inst_pc_next;
    logic        kill_reg, kill_next;
    logic        redir_held_reg, redir_held_next;
    logic        redirect_bad;
    logic        redirect_ok;

    assign redirect_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign redirect_ok  = redirect_i && !redirect_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            pc_reg         <= RESET_PC;
            inst_reg       <= NOP_INST;
            inst_pc_reg    <= RESET_PC;
            kill_reg       <= 1'b0;
            redir_held_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            inst_reg       <= inst_next;
            inst_pc_reg    <= inst_pc_next;
            kill_reg       <= kill_next;
            redir_held_reg <= redir_held_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        inst_next       = inst_reg;
        inst_pc_next    = inst_pc_reg;
        kill_next       = kill_reg;
        redir_held_next = redir_held_reg;
        case (state_reg)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (redirect_bad) begin
                    state_next = S_ERR;
                end else begin
                    if (redirect_ok) pc_next = redirect_pc_i;
                    // Old address is already on the bus; a same-cycle redirect must kill its reply.
                    if (imem_req_ready_i) begin
                        state_next = S_WAIT;
                        kill_next  = redirect_ok;
                    end
                end
            end
            S_WAIT: begin
                if (redirect_bad) begin
                    state_next = S_ERR;
                    kill_next  = 1'b0;
                end else if (imem_rsp_valid_i) begin
                    kill_next = 1'b0;
                    if (imem_rsp_err_i) begin
                        state_next = S_ERR;
                    end else begin
                        if (redirect_ok) pc_next = redirect_pc_i;
                        if (kill_reg || redirect_ok) begin
                            state_next = S_REQ;
                        end else begin
                            // pc_reg is untouched since acceptance when no kill is pending.
                            state_next      = S_HOLD;
                            inst_next       = imem_rsp_data_i;
                            inst_pc_next    = pc_reg;
                            redir_held_next = 1'b0;
                        end
                    end
                end else if (redirect_ok) begin
                    pc_next   = redirect_pc_i;
                    kill_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_bad) begin
                    state_next = S_ERR;
                    inst_next  = NOP_INST;
                end else if (inst_ready_i) begin
                    state_next      = S_REQ;
                    inst_next       = NOP_INST;
                    redir_held_next = 1'b0;
                    if (redirect_ok)
                        pc_next = redirect_pc_i;
                    else if (!redir_held_reg)
                        pc_next = pc_reg + 32'd4;
                end else if (redirect_ok) begin
                    // Remember that pc already holds the next target so retirement skips +4.
                    pc_next         = redirect_pc_i;
                    redir_held_next = 1'b1;
                end
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_ERR;
        endcase
    end

    assign imem_req_valid_o = (state_reg == S_REQ);
    assign imem_addr_o      = pc_reg;
    assign inst_valid_o     = (state_reg == S_HOLD);
    assign inst_o           = inst_reg;
    assign pc_o             = inst_pc_reg;
    assign opcode_o         = inst_reg[6:0];
    assign func3_o          = inst_reg[14:12];
    assign func7_o          = inst_reg[31:25];
    assign fetch_err_o      = (state_reg == S_ERR);

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: transaction-level fetch model plus a latency-randomised
// instruction memory, directed scenarios followed by random traffic.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = 32'd0;
    logic        imem_rsp_err_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [6:0]  opcode_o;
    logic [2:0]  func3_o;
    logic [6:0]  func7_o;
    logic        fetch_err_o;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .opcode_o         (opcode_o),
        .func3_o          (func3_o),
        .func7_o          (func7_o),
        .fetch_err_o      (fetch_err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the fetch unit is doing, in transaction terms.
    bit          m_started, m_err, m_out, m_stale, m_have, m_redirected;
    logic [31:0] m_fetch_pc, m_req_addr, m_inst, m_inst_pc;

    // Memory environment.
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;

    // Per-cycle stimulus knobs.
    bit          d_rst, d_ready, d_redir, d_irdy, d_err;
    logic [31:0] d_rpc;
    int          lat_sel;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic bit m_requesting();
        return m_started && !m_err && !m_out && !m_have;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_err = 0; m_out = 0; m_stale = 0; m_have = 0; m_redirected = 0;
        m_fetch_pc = RESET_PC; m_req_addr = RESET_PC; m_inst = NOP; m_inst_pc = RESET_PC;
        mem_pend = 0; mem_cnt = 0; mem_addr = 32'd0;
    endtask

    task automatic compare_all();
        logic [31:0] ei;
        ei = m_have ? m_inst : NOP;
        chk1("req_valid", imem_req_valid_o, m_requesting());
        if (m_requesting()) chk("imem_addr", imem_addr_o, m_fetch_pc);
        chk1("inst_valid", inst_valid_o, m_have);
        chk("inst", inst_o, ei);
        if (m_have) chk("pc_o", pc_o, m_inst_pc);
        chk("opcode", {25'd0, opcode_o}, {25'd0, ei[6:0]});
        chk("func3", {29'd0, func3_o}, {29'd0, ei[14:12]});
        chk("func7", {25'd0, func7_o}, {25'd0, ei[31:25]});
        chk1("fetch_err", fetch_err_o, m_err);
    endtask

    // One clock cycle: check outputs, drive inputs, advance memory and model, cross the edge.
    task automatic step();
        bit rv, acc, mis;
        logic [31:0] r;
        compare_all();
        rst              = d_rst;
        imem_req_ready_i = d_ready;
        redirect_i       = d_redir;
        redirect_pc_i    = d_rpc;
        inst_ready_i     = d_irdy;
        rv  = d_rst && mem_pend && (mem_cnt == 0);
        acc = d_rst && imem_req_valid_o && d_ready;
        r = $urandom;
        imem_rsp_valid_i = rv;
        imem_rsp_data_i  = rv ? mem_word(mem_addr) : r;
        imem_rsp_err_i   = rv ? d_err : r[0];
        if (!d_rst) begin
            mem_pend = 0;
        end else begin
            if (rv) mem_pend = 0;
            else if (mem_pend) mem_cnt--;
            if (acc) begin
                n_checks++;
                if (mem_pend) begin
                    n_fail++;
                    $display("FAIL one_outstanding: new request %08h while %08h pending", imem_addr_o, mem_addr);
                end
                mem_pend = 1;
                mem_addr = imem_addr_o;
                mem_cnt  = (lat_sel < 0) ? $urandom_range(0, 3) : lat_sel;
            end
        end
        mis = d_redir && (d_rpc[1:0] != 2'b00);
        if (!d_rst) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1;
        end else if (!m_err) begin
            if (mis) begin
                m_err = 1; m_have = 0; m_out = 0;
            end else if (!m_out && !m_have) begin
                if (d_ready) begin
                    m_out = 1; m_stale = d_redir; m_req_addr = m_fetch_pc;
                end
                if (d_redir) m_fetch_pc = d_rpc;
            end else if (m_out) begin
                if (rv) begin
                    m_out = 0;
                    if (d_err) begin
                        m_err = 1;
                    end else begin
                        if (d_redir) m_fetch_pc = d_rpc;
                        if (!(m_stale || d_redir)) begin
                            m_have = 1; m_inst = mem_word(m_req_addr);
                            m_inst_pc = m_req_addr; m_redirected = 0;
                        end
                        m_stale = 0;
                    end
                end else if (d_redir) begin
                    m_stale = 1; m_fetch_pc = d_rpc;
                end
            end else begin
                if (d_irdy) begin
                    m_have = 0;
                    $display("retire pc=%08h inst=%08h", m_inst_pc, m_inst);
                    if (d_redir) m_fetch_pc = d_rpc;
                    else if (!m_redirected) m_fetch_pc = m_fetch_pc + 32'd4;
                end else if (d_redir) begin
                    m_fetch_pc = d_rpc; m_redirected = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input bit want_inst, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            hit = want_inst ? inst_valid_o : imem_req_valid_o;
            if (hit) break;
            step();
        end
        chk1(name, hit, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        model_reset();
        d_rst = 0; d_ready = 1; d_redir = 0; d_irdy = 0; d_err = 0; d_rpc = 0; lat_sel = 0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_inst", inst_o, NOP);
        chk("rst_pc_o", pc_o, RESET_PC);
        chk1("rst_req_valid", imem_req_valid_o, 1'b0);
        chk1("rst_inst_valid", inst_valid_o, 1'b0);
        chk1("rst_fetch_err", fetch_err_o, 1'b0);
        step();
        d_rst = 1;
        step();
        chk1("t1_req", imem_req_valid_o, 1'b1);
        chk("t1_addr", imem_addr_o, 32'h8000_0000);
        step();
        chk1("t1_wait_no_valid", inst_valid_o, 1'b0);
        step();
        chk1("t1_valid", inst_valid_o, 1'b1);
        chk("t1_inst", inst_o, 32'h0050_0093);
        chk("t1_opcode", {25'd0, opcode_o}, 32'h13);
        chk("t1_func3", {29'd0, func3_o}, 32'h0);
        chk("t1_pc_o", pc_o, 32'h8000_0000);
        repeat (5) begin
            step();
            chk1("t2_no_req_in_hold", imem_req_valid_o, 1'b0);
            chk("t2_inst_stable", inst_o, 32'h0050_0093);
        end
        d_irdy = 1; step(); d_irdy = 0;
        chk("t2_next_addr", imem_addr_o, 32'h8000_0004);

        lat_sel = 2;
        step();
        d_redir = 1; d_rpc = 32'h8000_0100; step(); d_redir = 0;
        wait_until(0, "t3_req_timeout");
        chk("t3_redirect_addr", imem_addr_o, 32'h8000_0100);

        lat_sel = 0;
        wait_until(1, "t4_hold_timeout");
        d_irdy = 1; d_redir = 1; d_rpc = 32'h8000_0200; step(); d_irdy = 0; d_redir = 0;
        chk("t4_redirect_wins", imem_addr_o, 32'h8000_0200);

        d_ready = 0; d_redir = 1; d_rpc = 32'hFFFF_FFFC; step(); d_redir = 0;
        chk("t5_req_redirect", imem_addr_o, 32'hFFFF_FFFC);
        d_ready = 1;
        wait_until(1, "t5_hold_timeout");
        chk("t5_pc_o", pc_o, 32'hFFFF_FFFC);
        d_irdy = 1; step(); d_irdy = 0;
        chk("t5_wrap_addr", imem_addr_o, 32'h0000_0000);

        lat_sel = 3;
        step(); step();
        d_rst = 0; step(); step(); d_rst = 1;
        step();
        chk("t6_restart_addr", imem_addr_o, RESET_PC);

        lat_sel = 1;
        d_redir = 1; d_rpc = 32'h8000_0400; step(); d_redir = 0;
        wait_until(0, "t7_req_timeout");
        chk("t7_kill_accept_addr", imem_addr_o, 32'h8000_0400);

        lat_sel = 0;
        wait_until(1, "t8_hold_timeout");
        d_redir = 1; d_rpc = 32'h8000_0102; step(); d_redir = 0; d_irdy = 1;
        repeat (8) step();
        chk1("t8_misalign_err", fetch_err_o, 1'b1);
        chk1("t8_misalign_no_req", imem_req_valid_o, 1'b0);
        d_irdy = 0;

        d_rst = 0; step(); d_rst = 1; d_err = 1;
        repeat (6) step();
        chk1("t9_rsp_err", fetch_err_o, 1'b1);
        chk1("t9_rsp_err_no_req", imem_req_valid_o, 1'b0);
        d_err = 0; d_rst = 0; step(); d_rst = 1;

        lat_sel = -1;
        for (int c = 0; c < 6000; c++) begin
            d_ready = ($urandom % 4) != 0;
            d_irdy  = ($urandom % 3) != 0;
            d_redir = ($urandom % 10) == 0;
            r = $urandom;
            case ($urandom % 4)
                0:       d_rpc = 32'hFFFF_FFFC;
                1:       d_rpc = 32'h8000_0000 + {r[29:24], 2'b00};
                default: d_rpc = {r[31:2], 2'b00};
            endcase
            if (c >= 3000) begin
                d_err = ($urandom % 25) == 0;
                if (($urandom % 40) == 0) d_rpc[1:0] = 2'($urandom_range(1, 3));
                d_rst = m_err ? (($urandom % 8) != 0) : (($urandom % 150) != 0);
            end
            step();
        end
        d_rst = 1; d_redir = 0; d_err = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
